// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT FSM, 32-entry register file, req/ack memories.
// Optional beq/bne support is enabled by defining MIPS_MULTICYCLE_BRANCH_EN.
module mips_multicycle_core #(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 10,
    parameter int DMEM_AW = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [IMEM_AW-1:0]   imem_addr,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_rdata,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DMEM_AW-1:0]   dmem_addr,
    output logic [XLEN-1:0]      dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic [IMEM_AW+1:0]   pc,
    output logic                 retire,
    output logic                 halted
);
    localparam int PW = IMEM_AW + 2;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [PW-1:0]   pc_q, pc_d, ipc_q, ipc_d;
    logic            armed_q, armed_d;
    logic            retire_q, retire_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [XLEN-1:0] rf_q [32];
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    logic [5:0]      op, funct;
    logic [4:0]      rs, rt, rd, shamt;
    logic [15:0]     imm;
    logic [XLEN-1:0] simm, zimm;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign shamt = ir_q[10:6];
    assign funct = ir_q[5:0];
    assign imm   = ir_q[15:0];
    assign simm  = {{(XLEN-16){imm[15]}}, imm};
    assign zimm  = {{(XLEN-16){1'b0}}, imm};

`ifdef MIPS_MULTICYCLE_BRANCH_EN
    logic [PW-1:0] boff;
    assign boff = PW'({{14{imm[15]}}, imm, 2'b00});
`endif

    // The first cycle after reset holds imem_req low; armed_q opens the fetch one cycle later.
    assign imem_req   = (state_q == S_FETCH) && armed_q;
    assign imem_addr  = pc_q[IMEM_AW+1:2];
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = dmem_req && (op == 6'd43);
    assign dmem_addr  = res_q[DMEM_AW+1:2];
    assign dmem_wdata = dmem_req ? b_q : '0;
    assign pc         = (state_q == S_FETCH) ? pc_q : ipc_q;
    assign retire     = retire_q;
    assign halted     = (state_q == S_HALT);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ipc_d    = ipc_q;
        armed_d  = 1'b1;
        retire_d = 1'b0;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        rf_we    = 1'b0;
        rf_waddr = (op == 6'd0) ? rd : rt;
        rf_wdata = res_q;
        case (state_q)
            S_FETCH: begin
                if (imem_req && imem_ack) begin
                    ir_d    = imem_rdata;
                    ipc_d   = pc_q;
                    pc_d    = pc_q + PW'(4);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = (rs == 5'd0) ? '0 : rf_q[rs];
                b_d     = (rt == 5'd0) ? '0 : rf_q[rt];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Unrecognised encodings fall through as NOPs that retire here.
                state_d  = S_FETCH;
                retire_d = 1'b1;
                case (op)
                    6'd0: begin
                        state_d  = S_WB;
                        retire_d = 1'b0;
                        case (funct)
                            6'd0:    res_d = b_q << shamt;
                            6'd2:    res_d = b_q >> shamt;
                            6'd32:   res_d = a_q + b_q;
                            6'd34:   res_d = a_q - b_q;
                            6'd36:   res_d = a_q & b_q;
                            6'd37:   res_d = a_q | b_q;
                            6'd38:   res_d = a_q ^ b_q;
                            6'd39:   res_d = ~(a_q | b_q);
                            default: begin
                                state_d  = S_FETCH;
                                retire_d = 1'b1;
                            end
                        endcase
                    end
                    6'd8:  begin res_d = a_q + simm; state_d = S_WB; retire_d = 1'b0; end
                    6'd12: begin res_d = a_q & zimm; state_d = S_WB; retire_d = 1'b0; end
                    6'd13: begin res_d = a_q | zimm; state_d = S_WB; retire_d = 1'b0; end
                    6'd14: begin res_d = a_q ^ zimm; state_d = S_WB; retire_d = 1'b0; end
                    6'd35, 6'd43: begin
                        res_d    = a_q + simm;
                        state_d  = S_MEM;
                        retire_d = 1'b0;
                    end
`ifdef MIPS_MULTICYCLE_BRANCH_EN
                    6'd4, 6'd5: begin
                        if ((a_q == b_q) == (op == 6'd4)) pc_d = pc_q + boff;
                    end
`endif
                    6'd63:   state_d = S_HALT;
                    default: ;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (op == 6'd43) begin
                        state_d  = S_FETCH;
                        retire_d = 1'b1;
                    end else begin
                        res_d   = dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                state_d  = S_FETCH;
                retire_d = 1'b1;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ipc_q    <= '0;
            armed_q  <= 1'b0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ipc_q    <= ipc_d;
            armed_q  <= armed_d;
            retire_q <= retire_d;
        end
    end

    always_ff @(posedge clock) begin
        ir_q  <= ir_d;
        a_q   <= a_d;
        b_q   <= b_d;
        res_q <= res_d;
    end

    // Register 0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: ISA-level reference model feeds scoreboard queues checked by a monitor.
module tb_mips_multicycle_core;
    logic        clock, reset;
    logic        imem_req, imem_ack;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic [11:0] pc;
    logic        retire, halted;

    mips_multicycle_core dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc(pc), .retire(retire), .halted(halted)
    );

    localparam logic [31:0] HALT = 32'hFC000000;

    typedef struct packed {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wd;
    } dexp_t;

    logic [31:0] imem [1024];
    logic [31:0] dmem [1024];
    logic [31:0] prog [$];
    logic [9:0]  fq [$];
    dexp_t       dq [$];
    int          lq [$];

    int checks = 0, errors = 0;
    int cyc = 0;
    int imin = 0, imax = 0, dmin = 0, dmax = 0;
    int iw = 0, dw = 0;
    bit ipend = 0, dpend = 0;
    bit mon_en = 0, started = 0;
    int last = 0, waits = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h expected=none", nm, act);
    endtask

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    // Instruction-set interpreter: one loop iteration per instruction, pushing expected bus traffic and latency.
    task automatic model_run();
        logic [31:0] r [32];
        logic [31:0] md [1024];
        logic [11:0] mpc, npc;
        logic [31:0] ins, a, b, se, ze, ea, v;
        int op, fn, sh, rs, rt, rd, lat, dst, steps;
        bit done, wr;
        fq.delete(); dq.delete(); lq.delete();
        for (int i = 0; i < 32; i++) r[i] = '0;
        for (int i = 0; i < 1024; i++) md[i] = dmem[i];
        mpc = '0; done = 0; steps = 0;
        while (!done && steps < 2000) begin
            steps++;
            fq.push_back(mpc[11:2]);
            ins = imem[mpc[11:2]];
            npc = mpc + 12'd4;
            op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]);
            rd = int'(ins[15:11]); sh = int'(ins[10:6]); fn = int'(ins[5:0]);
            a = r[rs]; b = r[rt];
            se = {{16{ins[15]}}, ins[15:0]};
            ze = {16'd0, ins[15:0]};
            ea = a + se;
            lat = 3; wr = 0; dst = rt; v = '0;
            if (op == 0) begin
                dst = rd; wr = 1; lat = 4;
                case (fn)
                    0: v = b << sh;
                    2: v = b >> sh;
                    32: v = a + b;
                    34: v = a - b;
                    36: v = a & b;
                    37: v = a | b;
                    38: v = a ^ b;
                    39: v = ~(a | b);
                    default: begin wr = 0; lat = 3; end
                endcase
            end else if (op == 8)  begin v = a + se; wr = 1; lat = 4; end
            else if (op == 12) begin v = a & ze; wr = 1; lat = 4; end
            else if (op == 13) begin v = a | ze; wr = 1; lat = 4; end
            else if (op == 14) begin v = a ^ ze; wr = 1; lat = 4; end
            else if (op == 35) begin
                dq.push_back('{we: 1'b0, addr: ea[11:2], wd: 32'd0});
                v = md[ea[11:2]]; wr = 1; lat = 5;
            end else if (op == 43) begin
                dq.push_back('{we: 1'b1, addr: ea[11:2], wd: b});
                md[ea[11:2]] = b; lat = 4;
            end else if (op == 63) begin
                done = 1;
            end
`ifdef MIPS_MULTICYCLE_BRANCH_EN
            else if ((op == 4 && a == b) || (op == 5 && a != b)) begin
                npc = npc + {se[9:0], 2'b00};
            end
`endif
            if (wr && dst != 0) r[dst] = v;
            lq.push_back(lat);
            mpc = npc;
        end
    endtask

    // Memory models: random wait-states per request, random spurious acks while idle.
    always @(posedge clock) begin
        #1;
        if (reset) begin
            ipend = 0; dpend = 0;
            imem_ack = 1'($urandom % 2);
            dmem_ack = 1'($urandom % 2);
        end else begin
            if (imem_req) begin
                if (!ipend) begin ipend = 1; iw = $urandom_range(imax, imin); end
                if (iw == 0) begin
                    imem_ack = 1'b1; imem_rdata = imem[imem_addr]; ipend = 0;
                end else begin
                    imem_ack = 1'b0; iw--;
                end
            end else begin
                ipend = 0; imem_ack = 1'($urandom % 2); imem_rdata = $urandom;
            end
            if (dmem_req) begin
                if (!dpend) begin dpend = 1; dw = $urandom_range(dmax, dmin); end
                if (dw == 0) begin
                    dmem_ack = 1'b1; dpend = 0;
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    else dmem_rdata = dmem[dmem_addr];
                end else begin
                    dmem_ack = 1'b0; dw--;
                end
            end else begin
                dpend = 0; dmem_ack = 1'($urandom % 2); dmem_rdata = $urandom;
            end
        end
    end

    // Monitor: pops expectations whenever the core completes a handshake or retires.
    always @(negedge clock) begin
        if (reset) begin
            started = 0; waits = 0;
        end else if (mon_en) begin
            if (!started && imem_req) begin started = 1; last = cyc; waits = 0; end
            if (retire) begin
                if (lq.size() == 0) fail_now("retire_extra", 64'(cyc));
                else chk("retire_latency", 64'(cyc - last), 64'(lq.pop_front() + waits));
                last = cyc; waits = 0;
            end
            if (imem_req && imem_ack) begin
                if (fq.size() == 0) fail_now("fetch_extra", 64'(imem_addr));
                else begin
                    logic [9:0] w;
                    w = fq.pop_front();
                    chk("fetch_addr", 64'(imem_addr), 64'(w));
                    chk("fetch_pc", 64'(pc), 64'({w, 2'b00}));
                end
            end else if (imem_req) waits++;
            if (dmem_req && dmem_ack) begin
                if (dq.size() == 0) fail_now("dmem_extra", 64'(dmem_addr));
                else begin
                    dexp_t e;
                    e = dq.pop_front();
                    chk("dmem_we", 64'(dmem_we), 64'(e.we));
                    chk("dmem_addr", 64'(dmem_addr), 64'(e.addr));
                    if (e.we) chk("dmem_wdata", 64'(dmem_wdata), 64'(e.wd));
                end
            end else if (dmem_req) waits++;
        end
    end

    task automatic run_prog();
        for (int i = 0; i < 1024; i++) imem[i] = HALT;
        foreach (prog[i]) imem[i] = prog[i];
        model_run();
        mon_en = 0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_imem_req", 64'(imem_req), 0);
        chk("rst_dmem_req", 64'(dmem_req), 0);
        chk("rst_retire", 64'(retire), 0);
        chk("rst_halted", 64'(halted), 0);
        chk("rst_dmem_we", 64'(dmem_we), 0);
        chk("rst_dmem_wdata", 64'(dmem_wdata), 0);
        chk("rst_pc", 64'(pc), 0);
        reset = 1'b0;
        mon_en = 1;
        @(negedge clock);
        chk("first_fetch_req", 64'(imem_req), 1);
        for (int i = 0; i < 4000 && !halted; i++) @(negedge clock);
        if (!halted) fail_now("halt_timeout", 64'(pc));
        repeat (20) @(negedge clock);
        chk("halted_hold", 64'(halted), 1);
        chk("fetch_q_left", 64'(fq.size()), 0);
        chk("dmem_q_left", 64'(dq.size()), 0);
        chk("retire_q_left", 64'(lq.size()), 0);
        mon_en = 0;
    endtask

    initial begin
        int sel, fns [9];
        int iops [4];
        int uops [4];
        fns = '{0, 2, 32, 34, 36, 37, 38, 39, 1};
        iops = '{8, 12, 13, 14};
        uops = '{9, 15, 32, 50};
        reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        imem_rdata = '0; dmem_rdata = '0;
        for (int i = 0; i < 1024; i++) dmem[i] = $urandom;

        // ALU chain plus store/load with three data wait-states.
        imin = 0; imax = 0; dmin = 3; dmax = 3;
        prog = '{enc_i(8, 0, 1, 5), enc_i(8, 0, 2, -3), enc_r(1, 2, 3, 0, 32),
                 enc_i(43, 0, 3, 8), enc_i(35, 0, 4, 8), enc_i(43, 0, 4, 12), HALT};
        run_prog();
        chk("p1_sw_rf3", 64'(dmem[2]), 64'(32'd2));
        chk("p1_lw_rf4", 64'(dmem[3]), 64'(32'd2));

        // Halt at 0x0C after ori/sll/nor.
        dmin = 0; dmax = 0;
        prog = '{enc_i(13, 0, 5, 16'hFFFF), enc_r(0, 5, 6, 16, 0), enc_r(0, 0, 7, 0, 39), HALT};
        run_prog();

        prog = '{enc_i(13, 0, 5, 16'hFFFF), enc_r(0, 5, 6, 16, 0), enc_r(0, 0, 7, 0, 39),
                 enc_i(8, 0, 0, 7), enc_i(43, 0, 6, 32'h80), enc_i(43, 0, 7, 32'h84),
                 enc_i(43, 0, 0, 32'h88), HALT};
        run_prog();
        chk("p3_sll", 64'(dmem[32]), 64'(32'hFFFF0000));
        chk("p3_nor", 64'(dmem[33]), 64'(32'hFFFFFFFF));
        chk("p3_r0", 64'(dmem[34]), 0);

        // beq taken skips two instructions; bne on equal operands falls through.
        prog = '{enc_i(8, 0, 1, 1), enc_i(4, 1, 1, 2), enc_i(8, 0, 2, 9), enc_i(8, 0, 3, 9),
                 enc_i(5, 1, 1, 1), enc_i(8, 0, 4, 4), enc_i(43, 0, 2, 32'h90),
                 enc_i(43, 0, 4, 32'h94), enc_i(43, 0, 3, 32'h98), HALT};
        run_prog();
`ifdef MIPS_MULTICYCLE_BRANCH_EN
        chk("br_skip2", 64'(dmem[36]), 0);
        chk("br_skip3", 64'(dmem[38]), 0);
`else
        chk("br_nop2", 64'(dmem[36]), 64'(32'd9));
        chk("br_nop3", 64'(dmem[38]), 64'(32'd9));
`endif
        chk("br_fall", 64'(dmem[37]), 64'(32'd4));

        // Reset while a fetch is outstanding.
        imin = 1000; imax = 1000;
        mon_en = 0; reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("mid_req_high", 64'(imem_req), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_req_drop", 64'(imem_req), 0);
        chk("mid_pc_zero", 64'(pc), 0);
        imin = 0; imax = 2; dmin = 0; dmax = 2;
        prog = '{enc_i(8, 0, 1, 3), enc_i(43, 0, 1, 32'h40), HALT};
        run_prog();
        chk("mid_restart", 64'(dmem[16]), 64'(32'd3));

        // Random programs with random wait-states, ending with stores of every live register.
        for (int p = 0; p < 6; p++) begin
            prog.delete();
            for (int k = 0; k < 30; k++) begin
                sel = $urandom_range(9, 0);
                case (sel)
                    0, 1, 2, 9: prog.push_back(enc_r($urandom_range(7, 0), $urandom_range(7, 0),
                                    $urandom_range(7, 0), $urandom_range(31, 0), fns[$urandom_range(8, 0)]));
                    3, 4: prog.push_back(enc_i(iops[$urandom_range(3, 0)], $urandom_range(7, 0),
                                    $urandom_range(7, 0), $urandom_range(65535, 0)));
                    5: prog.push_back(enc_i(35, $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(65535, 0)));
                    6: prog.push_back(enc_i(43, $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(65535, 0)));
                    7: prog.push_back(enc_i(4 + $urandom_range(1, 0), $urandom_range(3, 0),
                                    $urandom_range(3, 0), $urandom_range(3, 0)));
                    default: prog.push_back(enc_i(uops[$urandom_range(3, 0)], $urandom_range(7, 0),
                                    $urandom_range(7, 0), $urandom_range(65535, 0)));
                endcase
            end
            for (int r = 1; r < 8; r++) prog.push_back(enc_i(43, 0, r, 32'h200 + 4 * r));
            prog.push_back(HALT);
            imax = p % 3; dmax = (p + 1) % 3;
            run_prog();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multicycle MIPS-subset core with a fetch/decode/execute/memory/writeback state machine and an internal 32-entry register file. It replaces the single-cycle CPU/register-file pair. Instruction and data memories are external, behind req/ack handshakes, so wait-states are tolerated. The core sits between the testbench clock generator and the memory models, and exposes retire/halt status for checking.

## Interface
Parameters:
- XLEN, 32: datapath and register width; legal values 32 or 64.
- IMEM_AW, 10: instruction memory word-address bits.
- DMEM_AW, 10: data memory word-address bits.

Ports:
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  IMEM_AW  word address; equals PC[IMEM_AW+1:2].
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DMEM_AW  word address; equals EA[DMEM_AW+1:2].
- dmem_wdata  out  XLEN  store data (rt).
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle for loads.
- dmem_rdata  in  XLEN  load data.
- pc  out  IMEM_AW+2  byte PC of the instruction in flight.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core stopped.

## Operation
- States: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. HALT is terminal until reset.
- FETCH:
  - imem_req is held high until the cycle where imem_ack=1.
  - On that edge, IR <= imem_rdata and the state moves to DECODE.
  - PC <= PC+4 on the same edge; PC wraps modulo 2^(IMEM_AW+2).
- DECODE: latch A=RF[rs] and B=RF[rt]. RF[0] always reads 0.
- EXEC:
  - R-type (op=0), by funct: 0 sll, 2 srl (rt shifted by shamt, logical), 32 add, 34 sub, 36 and, 37 or, 38 xor, 39 nor.
  - I-type: 8 addi (sign-extended imm), 12 andi / 13 ori / 14 xori (zero-extended imm).
  - Arithmetic wraps modulo 2^XLEN; no overflow trap.
- Loads and stores: 35 lw, 43 sw.
  - EA = rs + signext(imm); EA[1:0] ignored.
  - Go to MEM.
- MEM:
  - dmem_req is held with dmem_addr, dmem_we and dmem_wdata stable until dmem_ack.
  - sw: go to FETCH. lw: capture dmem_rdata and go to WB.
- WB:
  - Destination is rd for R-type, rt for I-type and lw.
  - Writes to register 0 are discarded.
- Op 63: enter HALT.
  - halted=1 and stays 1; no further requests are issued.
  - retire is pulsed once for the halt instruction.
- Any other opcode or funct: NOP, retires after EXEC.
- retire pulses for exactly one cycle, in the cycle after the final state of each instruction.

## Timing
- On reset, the state after the edge is:
  - State FETCH, PC=0, all RF entries 0.
  - imem_req=0 and dmem_req=0 for that first cycle; the core then enters FETCH with imem_req=1 next cycle.
  - retire=0, halted=0, dmem_we=0, dmem_wdata=0.
- Reset mid-handshake drops req on the next edge. Any pending ack is ignored.
- An ack may arrive in the same cycle req rises. An ack while req=0 is ignored.
- Minimum latency with zero wait-states, in cycles: ALU op 4 (F,D,E,W), lw 5, sw 4, NOP/halt 3, taken or untaken branch 3.
- Each wait-state adds exactly 1 cycle.
- Register write and the next DECODE read are separated by at least 2 edges, so no forwarding is needed.

## Configuration
- Macro: MIPS_MULTICYCLE_BRANCH_EN.
- Defined:
  - op 4 beq and op 5 bne compare A and B in EXEC.
  - If taken, PC <= PC + (signext(imm)<<2) on the EXEC edge, where PC is already incremented. Then go to FETCH.
- Undefined: ops 4 and 5 decode as NOP.

## Test plan
- Reset, then addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 -> RF[3]=2; retire pulses spaced 4 cycles; pc sequence 0,4,8.
- sw $3,8($0) then lw $4,8($0), with dmem_ack delayed 3 cycles -> dmem_addr=2, dmem_we=1 then 0, RF[4]=2; lw takes 8 cycles.
- ori $5,$0,0xFFFF; sll $6,$5,16; nor $7,$0,$0 -> RF[6]=0xFFFF0000 (XLEN=32); RF[7]=all ones; addi $0,$0,7 leaves $0 reading 0.
- With the branch macro: addi $1,$0,1; beq $1,$1,+2 -> next fetch at PC 0x10. bne $1,$1 -> falls through. Without the macro -> the branch is a NOP.
- Reset asserted while imem_req=1 and no ack -> next cycle imem_req=0, PC=0, then fetch restarts at address 0.
- Halt (0xFC000000) at PC 0x0C -> halted=1 and retire pulses once; no imem_req for 20 cycles afterwards.
